// File: rtl/bullcow_pkg.sv
// Shared types and constants for the Bulls-and-Cows turn controller.
package bullcow_pkg;

  // Game phases. The datapath already decodes 000/001/010/011/111.
  typedef enum logic [2:0] {
    SETUP1 = 3'b000,
    SETUP2 = 3'b001,
    GUESS1 = 3'b010,
    GUESS2 = 3'b011,
    SHOW1  = 3'b100,
    SHOW2  = 3'b101,
    END    = 3'b111
  } phase_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_J1   = 2'b01;
  localparam logic [1:0] WINNER_J2   = 2'b10;

  localparam logic [2:0] BULLS_TO_WIN = 3'd4;

  // Score counters stick at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bullcow_enter_conditioner.sv
// Enter button conditioning: 2-FF synchronizer, debounce, rising-edge pulse.
module bullcow_enter_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          enter_clean_reg;
  logic          enter_clean_d_reg;
  logic [CW-1:0] debounce_cnt_reg;
  logic          sync_out;

  assign sync_out = sync_reg[1];

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], enter};
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enter_clean_reg   <= 1'b0;
      enter_clean_d_reg <= 1'b0;
      debounce_cnt_reg  <= '0;
    end else begin
      enter_clean_d_reg <= enter_clean_reg;
      if (sync_out == enter_clean_reg) begin
        debounce_cnt_reg <= '0;
      end else if (debounce_cnt_reg == CNT_LAST) begin
        enter_clean_reg  <= sync_out;
        debounce_cnt_reg <= '0;
      end else begin
        debounce_cnt_reg <= debounce_cnt_reg + 1'b1;
      end
    end
  end

  // One cycle per debounced rising edge; holding the button gives nothing more.
  assign press = enter_clean_reg & ~enter_clean_d_reg;

endmodule

// File: rtl/bullcow_turn_controller.sv
// Game-flow controller: setup, alternating guesses, result display, end of game.
// Drives one-cycle strobes to the datapath, times each guess turn, keeps the match score.
module bullcow_turn_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TURN_TIMEOUT    = 1000,
  parameter int END_HOLD        = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter,
  input  logic       sw_valid,
  input  logic [2:0] bull_count,
  output logic       load_secret_j1,
  output logic       load_secret_j2,
  output logic       capture_j1,
  output logic       capture_j2,
  output logic       turn,
  output logic [2:0] phase,
  output logic       invalid_entry,
  output logic       turn_timeout,
  output logic [1:0] winner,
  output logic [7:0] j1_points,
  output logic [7:0] j2_points
);

  import bullcow_pkg::*;

  localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam int HW = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
  localparam int TIMER_LAST_INT = (TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMER_LAST_INT);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(END_HOLD - 1);

  logic press;

  phase_t        state_reg, state_next;
  logic          turn_reg, turn_next;
  logic [1:0]    winner_reg, winner_next;
  logic [7:0]    j1_points_reg, j1_points_next;
  logic [7:0]    j2_points_reg, j2_points_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          load1_reg, load1_next;
  logic          load2_reg, load2_next;
  logic          cap1_reg, cap1_next;
  logic          cap2_reg, cap2_next;
  logic          invalid_reg, invalid_next;
  logic          timeout_reg, timeout_next;

  logic is_guess;
  logic timeout_hit;
  logic hold_done;

  bullcow_enter_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clock(clock),
    .reset(reset),
    .enter(enter),
    .press(press)
  );

  assign is_guess    = (state_reg == GUESS1) || (state_reg == GUESS2);
  assign timeout_hit = (TURN_TIMEOUT != 0) && (timer_reg == TIMER_LAST);
  assign hold_done   = (hold_reg == HOLD_LAST);

  // Next-state, score and strobe decisions; every output is registered below.
  always_comb begin
    state_next     = state_reg;
    turn_next      = turn_reg;
    winner_next    = winner_reg;
    j1_points_next = j1_points_reg;
    j2_points_next = j2_points_reg;
    load1_next     = 1'b0;
    load2_next     = 1'b0;
    cap1_next      = 1'b0;
    cap2_next      = 1'b0;
    invalid_next   = 1'b0;
    timeout_next   = 1'b0;
    timer_next     = '0;
    hold_next      = '0;

    case (state_reg)
      SETUP1: begin
        if (press) begin
          if (sw_valid) begin
            load1_next  = 1'b1;
            winner_next = WINNER_NONE;
            state_next  = SETUP2;
          end else begin
            invalid_next = 1'b1;
          end
        end
      end
      SETUP2: begin
        if (press) begin
          if (sw_valid) begin
            load2_next = 1'b1;
            turn_next  = 1'b0;
            state_next = GUESS1;
          end else begin
            invalid_next = 1'b1;
          end
        end
      end
      GUESS1, GUESS2: begin
        // A valid press beats a same-cycle expiry; an invalid one does not.
        if (press && sw_valid) begin
          if (state_reg == GUESS1) begin
            cap1_next = 1'b1;
          end else begin
            cap2_next = 1'b1;
          end
          if (bull_count == BULLS_TO_WIN) begin
            state_next = END;
            if (state_reg == GUESS1) begin
              winner_next    = WINNER_J1;
              j1_points_next = sat_inc8(j1_points_reg);
            end else begin
              winner_next    = WINNER_J2;
              j2_points_next = sat_inc8(j2_points_reg);
            end
          end else begin
            state_next = (state_reg == GUESS1) ? SHOW1 : SHOW2;
          end
        end else begin
          if (press) begin
            invalid_next = 1'b1;
          end
          if (timeout_hit) begin
            timeout_next = 1'b1;
            state_next   = (state_reg == GUESS1) ? GUESS2 : GUESS1;
            turn_next    = (state_reg == GUESS1);
          end
        end
      end
      SHOW1: begin
        if (press) begin
          state_next = GUESS2;
          turn_next  = 1'b1;
        end
      end
      SHOW2: begin
        if (press) begin
          state_next = GUESS1;
          turn_next  = 1'b0;
        end
      end
      END: begin
        if (hold_done) begin
          state_next = SETUP1;
          turn_next  = 1'b0;
        end
      end
      default: begin
        state_next = SETUP1;
        turn_next  = 1'b0;
      end
    endcase

    // Timers restart on every phase entry and only run while the phase is held.
    if ((TURN_TIMEOUT != 0) && is_guess && (state_next == state_reg)) begin
      timer_next = timer_reg + 1'b1;
    end
    if ((state_reg == END) && (state_next == END)) begin
      hold_next = hold_reg + 1'b1;
    end
  end

  // State, score, timers and output strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= SETUP1;
      turn_reg      <= 1'b0;
      winner_reg    <= WINNER_NONE;
      j1_points_reg <= 8'd0;
      j2_points_reg <= 8'd0;
      timer_reg     <= '0;
      hold_reg      <= '0;
      load1_reg     <= 1'b0;
      load2_reg     <= 1'b0;
      cap1_reg      <= 1'b0;
      cap2_reg      <= 1'b0;
      invalid_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      turn_reg      <= turn_next;
      winner_reg    <= winner_next;
      j1_points_reg <= j1_points_next;
      j2_points_reg <= j2_points_next;
      timer_reg     <= timer_next;
      hold_reg      <= hold_next;
      load1_reg     <= load1_next;
      load2_reg     <= load2_next;
      cap1_reg      <= cap1_next;
      cap2_reg      <= cap2_next;
      invalid_reg   <= invalid_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign load_secret_j1 = load1_reg;
  assign load_secret_j2 = load2_reg;
  assign capture_j1     = cap1_reg;
  assign capture_j2     = cap2_reg;
  assign turn           = turn_reg;
  assign phase          = state_reg;
  assign invalid_entry  = invalid_reg;
  assign turn_timeout   = timeout_reg;
  assign winner         = winner_reg;
  assign j1_points      = j1_points_reg;
  assign j2_points      = j2_points_reg;

endmodule

// File: tb/tb_bullcow_turn_controller.sv
// Bench for bullcow_turn_controller: table of press transactions, hand-written
// timing corners, and random button traffic checked every cycle against a game model.
module tb_bullcow_turn_controller;

  localparam int D  = 4;
  localparam int TO = 20;
  localparam int EH = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic       sw_valid = 1'b0;
  logic [2:0] bull_count = 3'd0;
  logic       load_secret_j1, load_secret_j2, capture_j1, capture_j2;
  logic       turn, invalid_entry, turn_timeout;
  logic [2:0] phase;
  logic [1:0] winner;
  logic [7:0] j1_points, j2_points;

  always #5 clock = ~clock;

  bullcow_turn_controller #(
    .DEBOUNCE_CYCLES(D),
    .TURN_TIMEOUT(TO),
    .END_HOLD(EH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enter(enter),
    .sw_valid(sw_valid),
    .bull_count(bull_count),
    .load_secret_j1(load_secret_j1),
    .load_secret_j2(load_secret_j2),
    .capture_j1(capture_j1),
    .capture_j2(capture_j2),
    .turn(turn),
    .phase(phase),
    .invalid_entry(invalid_entry),
    .turn_timeout(turn_timeout),
    .winner(winner),
    .j1_points(j1_points),
    .j2_points(j2_points)
  );

  int errors = 0;
  int checks = 0;

  // Game model: phase codes, who is up, how long the current phase has been shown.
  logic [2:0] m_phase;
  logic       m_turn;
  logic [1:0] m_winner;
  int         m_p1, m_p2;
  logic [5:0] m_pulses;   // {ld1, ld2, cap1, cap2, invalid, timeout}
  int         m_cycles_in;
  int         press_q[$]; // clock edges at which a debounced press reaches the FSM
  int         edge_no = 0;

  typedef struct {
    int         hi;
    int         lo;
    logic       v;
    logic [2:0] b;
    logic [5:0] exp_pulses;
    logic [2:0] exp_phase;
    logic       exp_turn;
    logic [1:0] exp_winner;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_pulses();
    return {load_secret_j1, load_secret_j2, capture_j1, capture_j2, invalid_entry, turn_timeout};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {4'b0, dut_pulses(), turn, phase, winner, j1_points, j2_points};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [7:0] a, b;
    a = m_p1[7:0];
    b = m_p2[7:0];
    return {4'b0, m_pulses, m_turn, m_phase, m_winner, a, b};
  endfunction

  task automatic model_reset();
    m_phase = 3'b000; m_turn = 1'b0; m_winner = 2'b00;
    m_p1 = 0; m_p2 = 0; m_pulses = 6'b0; m_cycles_in = 1;
    press_q.delete();
  endtask

  // One clock edge of game rules, with the press (if any) consumed at this edge.
  task automatic model_edge(input logic p, input logic v, input logic [2:0] b);
    logic [2:0] nph;
    logic       j2;
    m_pulses = 6'b0;
    nph = m_phase;
    j2 = m_phase[0];
    case (m_phase)
      3'b000: if (p && v) begin m_pulses[5] = 1'b1; nph = 3'b001; m_winner = 2'b00; end
              else if (p) m_pulses[1] = 1'b1;
      3'b001: if (p && v) begin m_pulses[4] = 1'b1; nph = 3'b010; m_turn = 1'b0; end
              else if (p) m_pulses[1] = 1'b1;
      3'b010, 3'b011: begin
        if (p && v) begin
          if (j2) m_pulses[2] = 1'b1; else m_pulses[3] = 1'b1;
          if (b == 3'd4) begin
            nph = 3'b111;
            m_winner = j2 ? 2'b10 : 2'b01;
            if (j2) begin if (m_p2 < 255) m_p2++; end
            else begin if (m_p1 < 255) m_p1++; end
          end else begin
            nph = j2 ? 3'b101 : 3'b100;
          end
        end else begin
          if (p) m_pulses[1] = 1'b1;
          if (m_cycles_in == TO) begin
            m_pulses[0] = 1'b1;
            nph = j2 ? 3'b010 : 3'b011;
            m_turn = !j2;
          end
        end
      end
      3'b100: if (p) begin nph = 3'b011; m_turn = 1'b1; end
      3'b101: if (p) begin nph = 3'b010; m_turn = 1'b0; end
      3'b111: if (m_cycles_in == EH) begin nph = 3'b000; m_turn = 1'b0; end
      default: begin nph = 3'b000; m_turn = 1'b0; end
    endcase
    m_cycles_in = (nph != m_phase) ? 1 : m_cycles_in + 1;
    m_phase = nph;
  endtask

  // Apply inputs at the falling edge, advance one clock, compare everything.
  task automatic step(input logic en, input logic v, input logic [2:0] b);
    logic p;
    enter = en; sw_valid = v; bull_count = b;
    @(posedge clock);
    edge_no++;
    p = 1'b0;
    if (press_q.size() > 0 && press_q[0] == edge_no) begin
      p = 1'b1;
      void'(press_q.pop_front());
    end
    model_edge(p, v, b);
    @(negedge clock);
    chk($sformatf("cycle %0d", edge_no), dut_vec(), model_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'd0);
  endtask

  // Button held for hi cycles then released for lo; a hold of D or more is one press,
  // reaching the FSM D+2 edges after the first edge that samples it high.
  task automatic pulse(input int hi, input int lo, input logic v, input logic [2:0] b,
                       output logic [5:0] obs, output int first_at, output int cnt);
    obs = 6'b0; first_at = 0; cnt = 0;
    if (hi >= D) press_q.push_back(edge_no + 1 + D + 2);
    for (int i = 0; i < hi + lo; i++) begin
      step(i < hi, v, b);
      if (dut_pulses() != 6'b0) begin
        obs = obs | dut_pulses();
        cnt++;
        if (first_at == 0) first_at = i + 1;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    enter = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_reset();
    chk({tag, " reset state"}, dut_vec(), 32'h0);
  endtask

  task automatic win_game(input logic j2);
    logic [5:0] o;
    int f, c;
    pulse(5, 6, 1'b1, 3'd0, o, f, c);
    pulse(5, 6, 1'b1, 3'd0, o, f, c);
    if (j2) begin
      pulse(5, 6, 1'b1, 3'd0, o, f, c);
      pulse(5, 6, 1'b1, 3'd0, o, f, c);
    end
    pulse(5, 6, 1'b1, 3'd4, o, f, c);
    idle(EH);
    chk("game back to setup1", {29'b0, phase}, 32'd0);
  endtask

  task automatic apply_row(input int i);
    logic [5:0] o;
    int f, c;
    pulse(tbl[i].hi, tbl[i].lo, tbl[i].v, tbl[i].b, o, f, c);
    chk($sformatf("row %0d pulses", i), {26'b0, o}, {26'b0, tbl[i].exp_pulses});
    chk($sformatf("row %0d phase", i), {29'b0, phase}, {29'b0, tbl[i].exp_phase});
    chk($sformatf("row %0d turn", i), {31'b0, turn}, {31'b0, tbl[i].exp_turn});
    chk($sformatf("row %0d winner", i), {30'b0, winner}, {30'b0, tbl[i].exp_winner});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] obs;
    int f, c, k;

    tbl[0] = '{3, 8, 1'b1, 3'd0, 6'b000000, 3'b000, 1'b0, 2'b00}; // glitch: no press
    tbl[1] = '{6, 6, 1'b0, 3'd0, 6'b000010, 3'b000, 1'b0, 2'b00}; // invalid secret
    tbl[2] = '{6, 6, 1'b1, 3'd0, 6'b100000, 3'b001, 1'b0, 2'b00};
    tbl[3] = '{5, 6, 1'b0, 3'd0, 6'b000010, 3'b001, 1'b0, 2'b00};
    tbl[4] = '{5, 6, 1'b1, 3'd0, 6'b010000, 3'b010, 1'b0, 2'b00};
    tbl[5] = '{5, 6, 1'b1, 3'd2, 6'b001000, 3'b100, 1'b0, 2'b00};
    tbl[6] = '{5, 6, 1'b0, 3'd0, 6'b000000, 3'b011, 1'b1, 2'b00}; // show ignores sw_valid
    tbl[7] = '{5, 6, 1'b1, 3'd4, 6'b000100, 3'b111, 1'b1, 2'b10}; // J2 wins
    tbl[8] = '{5, 6, 1'b1, 3'd0, 6'b100000, 3'b001, 1'b0, 2'b00}; // leaving SETUP1 clears winner

    // Latency: enter held from edge 1, single load strobe after edge 3+D.
    do_reset("initial");
    pulse(12, 6, 1'b1, 3'd0, obs, f, c);
    chk("latency first strobe edge", f, 7);
    chk("latency strobe count", c, 1);
    chk("latency strobe kind", {26'b0, obs}, 32'b100000);
    chk("latency phase", {29'b0, phase}, 32'd1);

    // Table of press transactions through a full game.
    do_reset("table");
    for (int i = 0; i < 8; i++) apply_row(i);
    chk("j2 points after win", {24'b0, j2_points}, 32'd1);
    idle(EH);
    chk("end returns to setup1", {29'b0, phase}, 32'd0);
    chk("winner held in setup1", {30'b0, winner}, 32'd2);
    apply_row(8);

    // Turn timeout: 20 cycles in GUESS1, then forfeit to J2 with no capture.
    pulse(5, 2, 1'b1, 3'd0, obs, f, c);
    chk("enter guess1", {29'b0, phase}, 32'd2);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 3'd0);
      if (turn_timeout === 1'b1) begin k = i; break; end
    end
    chk("timeout cycle guess1", k, 20);
    chk("timeout pulses guess1", {26'b0, dut_pulses()}, 32'b000001);
    chk("timeout phase guess1", {29'b0, phase}, 32'd3);
    chk("timeout turn guess1", {31'b0, turn}, 32'd1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 3'd0);
      if (turn_timeout === 1'b1) begin k = i; break; end
    end
    chk("timeout cycle guess2", k, 20);
    chk("timeout phase guess2", {29'b0, phase}, 32'd2);
    chk("timeout turn guess2", {31'b0, turn}, 32'd0);

    // Valid press landing on the expiry edge: capture wins, no timeout.
    idle(13);
    pulse(6, 8, 1'b1, 3'd1, obs, f, c);
    chk("valid at expiry pulses", {26'b0, obs}, 32'b001000);
    chk("valid at expiry phase", {29'b0, phase}, 32'd4);
    pulse(5, 2, 1'b1, 3'd0, obs, f, c);
    chk("show1 to guess2", {29'b0, phase}, 32'd3);

    // Invalid press landing on the expiry edge: both pulses, timeout taken.
    idle(13);
    pulse(6, 8, 1'b0, 3'd0, obs, f, c);
    chk("invalid at expiry pulses", {26'b0, obs}, 32'b000011);
    chk("invalid at expiry phase", {29'b0, phase}, 32'd2);

    // Invalid press mid-turn does not restart the turn timer.
    pulse(5, 6, 1'b0, 3'd0, obs, f, c);
    chk("midturn invalid pulses", {26'b0, obs}, 32'b000010);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 3'd0);
      if (turn_timeout === 1'b1) begin k = i; break; end
    end
    chk("timer kept running", k, 2);

    // Random button traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int hi, lo;
      logic v;
      logic [2:0] b;
      hi = $urandom_range(1, D + 3);
      lo = $urandom_range(D + 1, D + 14);
      if ($urandom_range(0, 7) == 0) lo = lo + $urandom_range(10, 30);
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      pulse(hi, lo, v, b, obs, f, c);
    end

    // Asynchronous reset mid-game with score 3/2 while in SHOW2.
    do_reset("score");
    win_game(1'b0); win_game(1'b0); win_game(1'b0);
    win_game(1'b1); win_game(1'b1);
    pulse(5, 6, 1'b1, 3'd0, obs, f, c);
    pulse(5, 6, 1'b1, 3'd0, obs, f, c);
    pulse(5, 6, 1'b1, 3'd0, obs, f, c);
    pulse(5, 6, 1'b1, 3'd0, obs, f, c);
    pulse(5, 6, 1'b1, 3'd1, obs, f, c);
    chk("in show2", {29'b0, phase}, 32'd5);
    chk("score before reset", {16'b0, j1_points, j2_points}, 32'h0302);
    #1 reset = 1'b0;
    #1 chk("async reset outputs", dut_vec(), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    pulse(5, 6, 1'b1, 3'd0, obs, f, c);
    chk("post reset first press", {26'b0, obs}, 32'b100000);
    chk("post reset phase", {29'b0, phase}, 32'd1);

    // Score saturation at 255.
    do_reset("saturation");
    for (int g = 0; g < 256; g++) begin
      win_game(1'b0);
      if (g == 254) chk("j1 points reach 255", {24'b0, j1_points}, 32'd255);
    end
    chk("j1 points saturate", {24'b0, j1_points}, 32'd255);
    chk("j2 points untouched", {24'b0, j2_points}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bullcow_turn_controller.md
Name: bullcow_turn_controller

Overview:
- Sequencing controller for the Bulls-and-Cows datapath (secret registers, guess scorer, validity checker).
- Conditions the raw enter button and runs the game flow: setup J1, setup J2, alternating guesses, result display, end of game.
- Issues one-cycle command strobes to the datapath, enforces a per-turn timeout, and keeps the match score.
- Sits between the board I/O and the scorer; the datapath holds no game state of its own.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before enter changes (>=1)
TURN_TIMEOUT, 1000, cycles allowed per guess turn; 0 disables the timeout
END_HOLD, 50, cycles spent in END before automatic return to SETUP1 (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
enter  in  1  raw push-button, asynchronous to clock
sw_valid  in  1  datapath flag: switch digits distinct and each <=9
bull_count  in  3  datapath bulls for current switches vs. opponent secret of the active turn
load_secret_j1  out  1  strobe: datapath latches switches as J1 secret
load_secret_j2  out  1  strobe: datapath latches switches as J2 secret
capture_j1  out  1  strobe: datapath registers J1 bull/cow result
capture_j2  out  1  strobe: datapath registers J2 bull/cow result
turn  out  1  0=J1 active, 1=J2 active (selects scorer's opponent secret)
phase  out  3  current FSM state (bullcow_pkg::phase_t)
invalid_entry  out  1  pulse: press rejected because sw_valid=0
turn_timeout  out  1  pulse: active player forfeited the turn
winner  out  2  00 none, 01 J1, 10 J2; held until next SETUP1 entry
j1_points  out  8  J1 wins, saturating
j2_points  out  8  J2 wins, saturating

Behaviour:
- Reset (reset=0, async):
  - phase=SETUP1, turn=0, winner=00.
  - All strobes and pulses 0; points 0.
  - Synchronizer, debounce counter and timers cleared; enter_clean=0.
  - Reset mid-game discards the game and the score.
- Enter conditioning:
  - 2-FF synchronizer, then debounce.
  - enter_clean takes the synchronized value after it has differed for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any agreement.
  - press = enter_clean & ~enter_clean_d, exactly one cycle per debounced rising edge.
- Latency: all outputs are registered. With enter held high and first sampled at edge 1, a resulting strobe is high for the one cycle following edge 3+DEBOUNCE_CYCLES. Holding enter produces no further presses.
- FSM:
  - SETUP1:
    - press & sw_valid: load_secret_j1, go to SETUP2.
    - press & !sw_valid: invalid_entry, stay.
  - SETUP2: same rules with load_secret_j2; on success go to GUESS1 (turn=0). Leaving SETUP1 clears winner.
  - GUESS1 / GUESS2:
    - Timer clears on entry.
    - press & sw_valid: capture_jX. If bull_count==4, go to END and winner=X; otherwise go to SHOWX.
    - press & !sw_valid: invalid_entry, stay. The timer keeps running.
    - Timer reaches TURN_TIMEOUT-1 with no valid press: turn_timeout, go to the other player's GUESS and toggle turn. No capture strobe is issued.
    - Valid press and expiry in the same cycle: the press wins.
    - Invalid press and expiry in the same cycle: both invalid_entry and turn_timeout pulse, and the timeout transition is taken.
  - SHOW1 / SHOW2:
    - Datapath displays the captured result.
    - press: go to the other GUESS and toggle turn. sw_valid is ignored.
    - No timeout in these states.
  - END:
    - On entry (same edge as the transition), the winner's points increment, saturating at 255.
    - Hold counter runs END_HOLD cycles, then go to SETUP1 (turn=0). winner stays until SETUP1 is left.
    - Presses in END are ignored.
  - Unused encodings go to SETUP1.
- bull_count is sampled only on the cycle a valid press is consumed in a GUESS state.
- Strobes are mutually exclusive; at most one of load_secret_j1, load_secret_j2, capture_j1, capture_j2 is high per cycle.

Decomposition:
- bullcow_pkg: phase_t enum (SETUP1=000, SETUP2=001, GUESS1=010, GUESS2=011, SHOW1=100, SHOW2=101, END=111), winner encodings, BULLS_TO_WIN=4. The datapath already uses 000/001/010/011/111.
- Sub-module bullcow_enter_conditioner: synchronizer + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES. Outputs press.
- Top: FSM, turn timer, END hold counter, score registers.

Test Plan:
- DEBOUNCE_CYCLES=4, sw_valid=1, enter held high from edge 1: load_secret_j1 high exactly in the cycle after edge 7 and once only; phase goes 000→001.
- Enter glitch high for 3 synchronized cycles, then low: no press, phase unchanged. Then sw_valid=0 with a clean press: invalid_entry pulses and phase stays 000.
- Full game: J1 guesses with bull_count=2, giving capture_j1 and phase=100. A press gives phase=011, turn=1. J2 guesses with bull_count=4, giving capture_j2, phase=111, winner=10, j2_points=1. After 50 cycles phase=000.
- TURN_TIMEOUT=20 in GUESS1 with no press: turn_timeout pulses at cycle 20, phase=011, turn=1, no capture strobe. A valid press coinciding with expiry gives capture_j1 and no timeout.
- Force j1_points=255 via repeated wins (or a short-run variant): a further J1 win keeps j1_points at 255.
- Assert reset during SHOW2 with points 3/2: all outputs return to reset values asynchronously. After deassertion the first valid press gives load_secret_j1.
